// File: rtl/vita_gearbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vita_gearbox_pkg
// Description : Shared types and constants for the VITA lane gearbox/aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package vita_gearbox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_VERIFY = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } align_state_t;

  localparam logic [7:0]  c_train_w8  = 8'hE9;
  localparam logic [9:0]  c_train_w10 = 10'h3A6;
  localparam logic [11:0] c_train_w12 = 12'hE9A;

  // slip_count must be able to hold OUT_W itself, hence the extra bit
  function automatic int slip_cnt_w(input int out_w);
    return $clog2(out_w) + 1;
  endfunction

  function automatic logic [11:0] default_train_word(input int out_w);
    case (out_w)
      8:       return {4'h0, c_train_w8};
      12:      return c_train_w12;
      default: return {2'b00, c_train_w10};
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vita_gearbox_align_if.sv
`default_nettype none
// ============================================================================
// Module      : vita_gearbox_align_if
// Description : Lane data/control bundle between deserializer side and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface vita_gearbox_align_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 10
) ();
  import vita_gearbox_pkg::*;

  localparam int c_sc_w = slip_cnt_w(OUT_W);

  logic [IN_W-1:0]   din;
  logic              bitslip;
  logic              align_en;
  logic [OUT_W-1:0]  dout;
  logic              dout_valid;
  logic              aligned;
  logic              align_fail;
  logic [c_sc_w-1:0] slip_count;

  modport master (
    output din, bitslip, align_en,
    input  dout, dout_valid, aligned, align_fail, slip_count
  );

  modport slave (
    input  din, bitslip, align_en,
    output dout, dout_valid, aligned, align_fail, slip_count
  );

endinterface
`default_nettype wire

// File: rtl/vita_gearbox_core.sv
`default_nettype none
// ============================================================================
// Module      : vita_gearbox_core
// Description : IN_W->OUT_W bit accumulator with single-bit slip and emit.
// Revision    : 1.0 - initial release
// ============================================================================
module vita_gearbox_core #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 10
) (
  input  logic             wclk,
  input  logic             reset,
  input  logic [IN_W-1:0]  din,
  input  logic             slip,
  output logic [OUT_W-1:0] word,
  output logic             valid
);

  localparam int c_acc_w = OUT_W + IN_W - 1;
  localparam int c_cnt_w = $clog2(c_acc_w + 1);

  logic [c_acc_w-1:0] r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic [OUT_W-1:0]   r_word;
  logic               r_valid;

  logic [c_acc_w-1:0] w_acc_nxt;
  logic [c_cnt_w-1:0] w_cnt_sum;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_cnt_w-1:0] w_shift;
  logic               w_emit;
  logic [OUT_W-1:0]   w_word;

  // Valid bits live in r_acc[r_cnt-1:0], oldest at the top; a slip drops din[0]
  always_comb begin
    w_acc_nxt = {r_acc[c_acc_w-IN_W-1:0], din};
    w_cnt_sum = r_cnt + c_cnt_w'(IN_W);
    if (slip) begin
      w_acc_nxt = {r_acc[c_acc_w-IN_W:0], din[IN_W-1:1]};
      w_cnt_sum = r_cnt + c_cnt_w'(IN_W - 1);
    end
    w_emit    = (w_cnt_sum >= c_cnt_w'(OUT_W));
    w_shift   = w_cnt_sum - c_cnt_w'(OUT_W);
    w_word    = OUT_W'(w_acc_nxt >> w_shift);
    w_cnt_nxt = w_emit ? w_shift : w_cnt_sum;
  end

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_emit;
      if (w_emit) begin
        r_word <= w_word;
      end
    end
  end

  assign word  = r_word;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/vita_gearbox_align.sv
`default_nettype none
// ============================================================================
// Module      : vita_gearbox_align
// Description : Lane gearbox with automatic training-word bitslip alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module vita_gearbox_align
  import vita_gearbox_pkg::*;
#(
  parameter int               IN_W       = 4,
  parameter int               OUT_W      = 10,
  parameter logic [OUT_W-1:0] TRAIN_WORD = OUT_W'(default_train_word(OUT_W)),
  parameter int               LOCK_CNT   = 16,
  parameter int               SLIP_WAIT  = 2
) (
  input  logic                 wclk,
  input  logic                 reset,
  vita_gearbox_align_if.slave  bus
);

  localparam int c_sc_w    = slip_cnt_w(OUT_W);
  localparam int c_wait_w  = $clog2(SLIP_WAIT + 2);
  localparam int c_match_w = $clog2(LOCK_CNT + 1);

  align_state_t         r_state,      w_state_nxt;
  logic [c_sc_w-1:0]    r_slip_count, w_slip_count_nxt;
  logic [c_wait_w-1:0]  r_wait,       w_wait_nxt;
  logic [c_match_w-1:0] r_match,      w_match_nxt;
  logic                 r_slip_req,   w_slip_req_nxt;

  logic                 w_slip;
  logic [OUT_W-1:0]     w_word;
  logic                 w_valid;
  logic                 w_is_train;
  logic [c_match_w-1:0] w_match_inc;

  // Manual slips only count while idle; FSM slips land the cycle after the decision
  assign w_slip = r_slip_req | ((r_state == ST_IDLE) & bus.bitslip);

  vita_gearbox_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .wclk  (wclk),
    .reset (reset),
    .din   (bus.din),
    .slip  (w_slip),
    .word  (w_word),
    .valid (w_valid)
  );

  assign w_is_train  = (w_word == TRAIN_WORD);
  assign w_match_inc = r_match + c_match_w'(1);

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_slip_count <= '0;
      r_wait       <= '0;
      r_match      <= '0;
      r_slip_req   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slip_count <= w_slip_count_nxt;
      r_wait       <= w_wait_nxt;
      r_match      <= w_match_nxt;
      r_slip_req   <= w_slip_req_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_slip_count_nxt = r_slip_count;
    w_wait_nxt       = r_wait;
    w_match_nxt      = r_match;
    w_slip_req_nxt   = 1'b0;

    if (!bus.align_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt      = ST_SEARCH;
          w_slip_count_nxt = '0;
          w_wait_nxt       = c_wait_w'(SLIP_WAIT);
        end
        ST_SEARCH: begin
          if (w_valid) begin
            if (r_wait != '0) begin
              w_wait_nxt = r_wait - c_wait_w'(1);
            end else if (w_is_train) begin
              w_match_nxt = c_match_w'(1);
              w_state_nxt = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
            end else if (r_slip_count < c_sc_w'(OUT_W)) begin
              w_slip_req_nxt   = 1'b1;
              w_slip_count_nxt = r_slip_count + c_sc_w'(1);
              w_wait_nxt       = c_wait_w'(SLIP_WAIT);
            end else begin
              w_state_nxt = ST_FAIL;
            end
          end
        end
        ST_VERIFY: begin
          if (w_valid) begin
            if (w_is_train) begin
              w_match_nxt = w_match_inc;
              if (w_match_inc >= c_match_w'(LOCK_CNT)) begin
                w_state_nxt = ST_LOCKED;
              end
            end else begin
              // Settle time already elapsed, so the next mismatch slips at once
              w_state_nxt = ST_SEARCH;
              w_wait_nxt  = '0;
            end
          end
        end
        ST_LOCKED, ST_FAIL: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dout       = w_word;
  assign bus.dout_valid = w_valid;
  assign bus.aligned    = (r_state == ST_LOCKED);
  assign bus.align_fail = (r_state == ST_FAIL);
  assign bus.slip_count = r_slip_count;

endmodule
`default_nettype wire

// File: tb/tb_vita_gearbox_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vita_gearbox_align
// Description : Randomised bench for three gearbox widths against a bit-FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vita_gearbox_align;

  localparam int IN_W   = 4;
  localparam int N      = 3;
  localparam int LOCK_N = 16;
  localparam int WAIT_N = 2;
  localparam int M_IDLE = 0, M_SEARCH = 1, M_VERIFY = 2, M_LOCKED = 3, M_FAIL = 4;

  logic wclk  = 1'b0;
  logic reset = 1'b1;
  always #5 wclk = ~wclk;

  vita_gearbox_align_if #(.IN_W(IN_W), .OUT_W(10)) bus0 ();
  vita_gearbox_align_if #(.IN_W(IN_W), .OUT_W(8))  bus1 ();
  vita_gearbox_align_if #(.IN_W(IN_W), .OUT_W(12)) bus2 ();

  vita_gearbox_align #(.IN_W(IN_W), .OUT_W(10), .TRAIN_WORD(10'h3A6),
    .LOCK_CNT(LOCK_N), .SLIP_WAIT(WAIT_N)) dut0 (.wclk(wclk), .reset(reset), .bus(bus0));
  vita_gearbox_align #(.IN_W(IN_W), .OUT_W(8), .TRAIN_WORD(8'hE9),
    .LOCK_CNT(LOCK_N), .SLIP_WAIT(WAIT_N)) dut1 (.wclk(wclk), .reset(reset), .bus(bus1));
  vita_gearbox_align #(.IN_W(IN_W), .OUT_W(12), .TRAIN_WORD(12'hE9A),
    .LOCK_CNT(LOCK_N), .SLIP_WAIT(WAIT_N)) dut2 (.wclk(wclk), .reset(reset), .bus(bus2));

  // Reference model: a bit FIFO per lane plus plain integer FSM bookkeeping
  bit fb [N][1024];
  int frd [N], fwr [N];
  int m_dout [N], m_st [N], m_sc [N], m_wait [N], m_match [N];
  bit m_valid [N], m_sreq [N];

  int src_pos [N], src_mode [N];   // mode 0 training, 1 random, 2 zero
  bit flip_req [N];
  int din_v [N];
  bit bslip, aen;
  int n_cmp = 0, n_err = 0;

  function automatic int ow_of(input int i);
    case (i) 0: return 10; 1: return 8; default: return 12; endcase
  endfunction

  function automatic int tw_of(input int i);
    case (i) 0: return 'h3A6; 1: return 'hE9; default: return 'hE9A; endcase
  endfunction

  function automatic int pack(input int d, input int v, input int a, input int f, input int sc);
    return (d << 8) | (v << 7) | (a << 6) | (f << 5) | sc;
  endfunction

  function automatic int got_pack(input int i);
    case (i)
      0: return pack(int'(bus0.dout), int'(bus0.dout_valid), int'(bus0.aligned),
                     int'(bus0.align_fail), int'(bus0.slip_count));
      1: return pack(int'(bus1.dout), int'(bus1.dout_valid), int'(bus1.aligned),
                     int'(bus1.align_fail), int'(bus1.slip_count));
      default: return pack(int'(bus2.dout), int'(bus2.dout_valid), int'(bus2.aligned),
                           int'(bus2.align_fail), int'(bus2.slip_count));
    endcase
  endfunction

  function automatic int exp_pack(input int i);
    return pack(m_dout[i], int'(m_valid[i]), int'(m_st[i] == M_LOCKED),
                int'(m_st[i] == M_FAIL), m_sc[i]);
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      frd[i] = 0; fwr[i] = 0; m_dout[i] = 0; m_valid[i] = 0; m_st[i] = M_IDLE;
      m_sc[i] = 0; m_wait[i] = 0; m_match[i] = 0; m_sreq[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int ow, word;
    bit slip, nsreq;
    ow    = ow_of(i);
    slip  = (m_st[i] == M_IDLE && bslip) || m_sreq[i];
    nsreq = 0;
    for (int b = IN_W - 1; b >= 0; b--) begin
      if (!(slip && b == 0)) begin
        fb[i][fwr[i] % 1024] = din_v[i][b];
        fwr[i]++;
      end
    end
    // FSM reacts to the word already on the outputs
    if (!aen) m_st[i] = M_IDLE;
    else case (m_st[i])
      M_IDLE: begin m_st[i] = M_SEARCH; m_sc[i] = 0; m_wait[i] = WAIT_N; end
      M_SEARCH: if (m_valid[i]) begin
        if (m_wait[i] > 0) m_wait[i]--;
        else if (m_dout[i] == tw_of(i)) begin
          m_match[i] = 1;
          m_st[i] = (m_match[i] >= LOCK_N) ? M_LOCKED : M_VERIFY;
        end else if (m_sc[i] < ow) begin
          nsreq = 1; m_sc[i]++; m_wait[i] = WAIT_N;
        end else m_st[i] = M_FAIL;
      end
      M_VERIFY: if (m_valid[i]) begin
        if (m_dout[i] == tw_of(i)) begin
          m_match[i]++;
          if (m_match[i] >= LOCK_N) m_st[i] = M_LOCKED;
        end else begin
          m_st[i] = M_SEARCH; m_wait[i] = 0;
        end
      end
      default: ;
    endcase
    m_sreq[i] = nsreq;
    if (fwr[i] - frd[i] >= ow) begin
      word = 0;
      for (int k = 0; k < ow; k++) begin
        word = (word << 1) | int'(fb[i][frd[i] % 1024]);
        frd[i]++;
      end
      m_dout[i]  = word;
      m_valid[i] = 1;
    end else m_valid[i] = 0;
  endtask

  task automatic gen_din(input int i);
    int v, t, ow;
    bit x;
    v = 0; t = tw_of(i); ow = ow_of(i);
    for (int b = IN_W - 1; b >= 0; b--) begin
      case (src_mode[i])
        0:       x = t[ow - 1 - (src_pos[i] % ow)];
        1:       x = 1'($urandom);
        default: x = 1'b0;
      endcase
      src_pos[i]++;
      v = v | (int'(x) << b);
    end
    if (flip_req[i]) begin v = v ^ 1; flip_req[i] = 0; end
    din_v[i] = v;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++)
      check_eq($sformatf("%s lane%0d", tag, i), got_pack(i), exp_pack(i));
  endtask

  task automatic tick();
    for (int i = 0; i < N; i++) gen_din(i);
    bus0.din = 4'(din_v[0]); bus1.din = 4'(din_v[1]); bus2.din = 4'(din_v[2]);
    bus0.bitslip = bslip; bus1.bitslip = bslip; bus2.bitslip = bslip;
    bus0.align_en = aen;  bus1.align_en = aen;  bus2.align_en = aen;
    @(posedge wclk);
    if (!reset) for (int i = 0; i < N; i++) model_step(i);
    #1;
    compare_all("cycle");
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Asserted between edges to exercise the asynchronous path
  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < N; i++) check_eq($sformatf("async reset lane%0d", i), got_pack(i), 0);
    @(posedge wclk);
    #1 reset = 1'b0;
  endtask

  task automatic set_src(input int mode, input int pos_seed);
    for (int i = 0; i < N; i++) begin
      src_mode[i] = mode; src_pos[i] = pos_seed % ow_of(i); flip_req[i] = 0;
    end
  endtask

  int strobes, rot, reached;
  bit done [N];

  initial begin
    bslip = 0; aen = 0;
    bus0.din = '0; bus1.din = '0; bus2.din = '0;
    bus0.bitslip = 0; bus1.bitslip = 0; bus2.bitslip = 0;
    bus0.align_en = 0; bus1.align_en = 0; bus2.align_en = 0;
    set_src(0, 0);
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    for (int i = 0; i < N; i++) check_eq($sformatf("reset state lane%0d", i), got_pack(i), 0);
    reset = 1'b0;

    // Aligned training stream, FSM off
    run(3);
    check_eq("A first word", got_pack(0) >> 8, 'h3A6);
    check_eq("A first strobe", (got_pack(0) >> 7) & 1, 1);
    run(2);
    check_eq("A second word", got_pack(0) >> 8, 'h3A6);
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      strobes += (got_pack(0) >> 7) & 1;
    end
    check_eq("A strobe rate", strobes, 16);
    check_eq("A not aligned", (got_pack(0) >> 6) & 1, 0);

    // One zero nibble ahead of the training stream, FSM on
    do_reset();
    set_src(2, 0); aen = 1;
    tick();
    set_src(0, 0);
    run(300);
    for (int i = 0; i < N; i++) check_eq($sformatf("B lock lane%0d", i), (got_pack(i) >> 6) & 1, 1);
    run(40);
    for (int i = 0; i < N; i++) check_eq($sformatf("B no slip after lock lane%0d", i), got_pack(i) & 31, m_sc[i]);

    // Lock from every starting offset
    for (int k = 0; k < 12; k++) begin
      aen = 0;
      do_reset();
      set_src(0, k); aen = 1;
      run(300);
      for (int i = 0; i < N; i++)
        check_eq($sformatf("sweep off%0d lane%0d", k, i), (got_pack(i) >> 6) & 1, 1);
    end

    // Manual bitslips while idle, then one ignored while searching
    aen = 0;
    do_reset();
    set_src(0, 0);
    run(10);
    for (int s = 0; s < 3; s++) begin bslip = 1; tick(); bslip = 0; run(3); end
    run(20);
    for (int i = 0; i < N; i++) begin
      rot = ((tw_of(i) << 3) | (tw_of(i) >> (ow_of(i) - 3))) & ((1 << ow_of(i)) - 1);
      check_eq($sformatf("C rotated word lane%0d", i), got_pack(i) >> 8, rot);
    end
    aen = 1; tick();
    bslip = 1; tick(); bslip = 0;
    run(2);
    for (int i = 0; i < N; i++) check_eq($sformatf("C slip ignored lane%0d", i), got_pack(i) & 31, 0);

    // No training word ever: exhaust slips and fail
    aen = 0;
    do_reset();
    set_src(2, 0); aen = 1;
    run(250);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("D fail lane%0d", i), (got_pack(i) >> 5) & 1, 1);
      check_eq($sformatf("D slips lane%0d", i), got_pack(i) & 31, ow_of(i));
    end
    aen = 0; run(2);
    for (int i = 0; i < N; i++) check_eq($sformatf("D fail cleared lane%0d", i), (got_pack(i) >> 5) & 1, 0);

    // Corrupt one word after five verify matches
    do_reset();
    set_src(0, 5); aen = 1;
    for (int i = 0; i < N; i++) done[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!done[i] && m_st[i] == M_VERIFY && m_match[i] == 5) begin
          flip_req[i] = 1; done[i] = 1;
        end
      tick();
    end
    for (int i = 0; i < N; i++) check_eq($sformatf("E relock lane%0d", i), (got_pack(i) >> 6) & 1, 1);

    // Reset while verifying, then fresh random data
    aen = 0;
    do_reset();
    set_src(0, 3); aen = 1;
    reached = 0;
    for (int c = 0; c < 300 && reached == 0; c++) begin
      tick();
      if (m_st[0] == M_VERIFY) reached = 1;
    end
    check_eq("F verify reached", reached, 1);
    do_reset();
    set_src(1, 0); aen = 0;
    run(30);

    // Free-running random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(39) == 0) begin
          src_mode[i] = ($urandom_range(3) == 0) ? 1 : 0;
          src_pos[i]  = $urandom_range(ow_of(i) - 1);
        end
      if ($urandom_range(59) == 0) aen = ~aen;
      bslip = ($urandom_range(9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
